// File: rtl/clk_int_div_multi.sv
// Multi-channel programmable integer clock divider with per-channel
// valid/ready divisor reload at period boundaries and a global sync restart.
module clk_int_div_multi #(
    parameter int unsigned CH      = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CH*WIDTH-1:0]   div_i,
    input  logic [CH-1:0]         div_valid_i,
    output logic [CH-1:0]         div_ready_o,
    output logic [CH-1:0]         done_o,
    input  logic                  sync_i,
    output logic [CH-1:0]         clk_o,
    output logic [CH-1:0]         clk_en_o
);

    // A divisor of 1 behaves as 2; folding it here keeps the counter logic uniform.
    localparam int unsigned DEF_EFF = (DEF_DIV == 1) ? 2 : DEF_DIV;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] pend_q;
        logic             pend_vld_q;
        logic             clk_q;
        logic             en_q;
        logic             done_q;

        logic [WIDTH-1:0] div_in;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] pend_eff;
        logic             stopped;
        logic             boundary;
        logic             accept;

        assign div_in   = div_i[c*WIDTH +: WIDTH];
        assign stopped  = (div_q == '0);
        assign boundary = stopped || (cnt_q == div_q - WIDTH'(1));
        assign hi       = div_q - (div_q >> 1);
        assign pend_eff = (pend_q == WIDTH'(1)) ? WIDTH'(2) : pend_q;
        // Accept and load are exclusive: a value accepted now waits for a later boundary.
        assign accept   = div_valid_i[c] && !pend_vld_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                div_q      <= WIDTH'(DEF_EFF);
                cnt_q      <= '0;
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                clk_q      <= 1'b0;
                en_q       <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                clk_q  <= !stopped && (cnt_q < hi);
                en_q   <= !stopped && (cnt_q == '0);
                done_q <= 1'b0;
                if (boundary && pend_vld_q) begin
                    div_q      <= pend_eff;
                    cnt_q      <= '0;
                    pend_vld_q <= 1'b0;
                    done_q     <= 1'b1;
                end else if (!stopped) begin
                    cnt_q <= (sync_i || boundary) ? '0 : cnt_q + WIDTH'(1);
                end
                if (accept) begin
                    pend_q     <= div_in;
                    pend_vld_q <= 1'b1;
                end
            end
        end

        assign div_ready_o[c] = !pend_vld_q;
        assign done_o[c]      = done_q;
        assign clk_o[c]       = clk_q;
        assign clk_en_o[c]    = en_q;
    end

endmodule

// File: tb/tb_clk_int_div_multi.sv
// Self-checking bench for clk_int_div_multi: directed scenarios plus random
// traffic compared against a period/phase reference model.
module tb_clk_int_div_multi;
    localparam int unsigned CH = 4;
    localparam int unsigned W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [CH*W-1:0]   div_i = '0;
    logic [CH-1:0]     div_valid_i = '0;
    logic [CH-1:0]     div_ready_o;
    logic [CH-1:0]     done_o;
    logic              sync_i = 1'b0;
    logic [CH-1:0]     clk_o;
    logic [CH-1:0]     clk_en_o;

    int total = 0;
    int bad   = 0;

    clk_int_div_multi #(.CH(CH), .WIDTH(W), .DEF_DIV(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .done_o      (done_o),
        .sync_i      (sync_i),
        .clk_o       (clk_o),
        .clk_en_o    (clk_en_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: each channel is a period length plus a position inside it.
    int          m_div  [CH];
    int          m_pos  [CH];
    int          m_pend [CH];
    logic [CH-1:0] m_clk, m_en, m_done, m_rdy;

    function automatic int period(input int d);
        return (d == 1) ? 2 : d;
    endfunction

    function automatic bit at_end(input int d, input int p);
        int per;
        per = period(d);
        return (per == 0) || (p == per - 1);
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < CH; c++) begin
                m_div[c]  <= 4;
                m_pos[c]  <= 0;
                m_pend[c] <= -1;
            end
            m_clk  <= '0;
            m_en   <= '0;
            m_done <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_clk[c]  <= (period(m_div[c]) != 0) && (m_pos[c] < (period(m_div[c]) + 1) / 2);
                m_en[c]   <= (period(m_div[c]) != 0) && (m_pos[c] == 0);
                m_done[c] <= at_end(m_div[c], m_pos[c]) && (m_pend[c] >= 0);
                if (at_end(m_div[c], m_pos[c]) && (m_pend[c] >= 0)) begin
                    m_div[c]  <= m_pend[c];
                    m_pos[c]  <= 0;
                    m_pend[c] <= -1;
                end else begin
                    if (period(m_div[c]) != 0)
                        m_pos[c] <= (sync_i || at_end(m_div[c], m_pos[c])) ? 0 : m_pos[c] + 1;
                    if ((m_pend[c] < 0) && div_valid_i[c])
                        m_pend[c] <= int'(div_i[c*W +: W]);
                end
            end
        end
    end

    always_comb begin
        m_rdy = '0;
        for (int c = 0; c < CH; c++) m_rdy[c] = (m_pend[c] < 0);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write(input int c, input int v);
        div_valid_i[c]     = 1'b1;
        div_i[c*W +: W]    = W'(v);
        cyc();
        div_valid_i[c]     = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #12;
        total++;
        if ({clk_o, clk_en_o, done_o, div_ready_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            bad++;
            $display("FAIL reset_values got=%h expected=%h", {clk_o, clk_en_o, done_o, div_ready_o}, {4'h0, 4'h0, 4'h0, 4'hF});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc();
        total++;
        if ({clk_o, clk_en_o} !== 8'hFF) begin
            bad++;
            $display("FAIL first_rise got=%h expected=ff", {clk_o, clk_en_o});
        end
    endtask

    task automatic test_pattern();
        logic [6:0] exp_clk;
        logic [6:0] exp_en;
        exp_clk = 7'b1001100;
        exp_en  = 7'b0001000;
        for (int i = 0; i < 7; i++) begin
            cyc();
            total++;
            if ({clk_o, clk_en_o} !== {{CH{exp_clk[6-i]}}, {CH{exp_en[6-i]}}}) begin
                bad++;
                $display("FAIL div4_pattern i=%0d got=%h expected=%h", i, {clk_o, clk_en_o},
                         {{CH{exp_clk[6-i]}}, {CH{exp_en[6-i]}}});
            end
        end
    endtask

    task automatic test_load();
        logic [9:0] pat;
        bit seen;
        int dones;
        pat   = 10'b1110011100;
        seen  = 0;
        dones = 0;
        cyc();
        write(0, 5);
        total++;
        if (div_ready_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_ready_low got=%b expected=0", div_ready_o[0]);
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            cyc();
            total++;
            if ({clk_o, clk_en_o, done_o, div_ready_o} !== {m_clk, m_en, m_done, m_rdy}) begin
                bad++;
                $display("FAIL load_model t=%0t got=%h expected=%h", $time,
                         {clk_o, clk_en_o, done_o, div_ready_o}, {m_clk, m_en, m_done, m_rdy});
            end
            if (done_o[0]) begin
                seen = 1;
                dones++;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL load_done_timeout got=none expected=pulse");
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done_o[0]) dones++;
            total++;
            if (clk_o[0] !== pat[9-i]) begin
                bad++;
                $display("FAIL div5_pattern i=%0d got=%b expected=%b", i, clk_o[0], pat[9-i]);
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL load_done_count got=%0d expected=1", dones);
        end
    endtask

    task automatic test_stop_restart();
        logic [11:0] pat;
        bit seen;
        pat  = 12'b111000111000;
        seen = 0;
        write(1, 0);
        for (int i = 0; i < 10 && !seen; i++) begin
            cyc();
            seen = done_o[1];
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stop_done_timeout got=none expected=pulse");
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++;
            if ({clk_o[1], clk_en_o[1]} !== 2'b00) begin
                bad++;
                $display("FAIL stopped_low i=%0d got=%b expected=00", i, {clk_o[1], clk_en_o[1]});
            end
        end
        write(1, 6);
        cyc();
        total++;
        if ({done_o[1], div_ready_o[1]} !== 2'b11) begin
            bad++;
            $display("FAIL stopped_done_latency got=%b expected=11", {done_o[1], div_ready_o[1]});
        end
        for (int i = 0; i < 12; i++) begin
            cyc();
            total++;
            if (clk_o[1] !== pat[11-i]) begin
                bad++;
                $display("FAIL div6_pattern i=%0d got=%b expected=%b", i, clk_o[1], pat[11-i]);
            end
        end
    endtask

    task automatic test_div1_stall();
        bit seen;
        seen = 0;
        div_valid_i[2] = 1'b1;
        div_i[2*W +: W] = W'(1);
        cyc();
        for (int i = 0; i < 12 && !seen; i++) begin
            div_i[2*W +: W] = W'($urandom_range(9, 3));
            cyc();
            total++;
            if ({clk_o, clk_en_o, done_o, div_ready_o} !== {m_clk, m_en, m_done, m_rdy}) begin
                bad++;
                $display("FAIL stall_model t=%0t got=%h expected=%h", $time,
                         {clk_o, clk_en_o, done_o, div_ready_o}, {m_clk, m_en, m_done, m_rdy});
            end
            if (done_o[2]) begin
                seen = 1;
                div_valid_i[2] = 1'b0;
            end
        end
        div_valid_i[2] = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stall_done_timeout got=none expected=pulse");
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            total++;
            if (clk_o[2] !== ((i % 2) == 0)) begin
                bad++;
                $display("FAIL div1_pattern i=%0d got=%b expected=%b", i, clk_o[2], (i % 2) == 0);
            end
        end
    endtask

    task automatic test_sync();
        bit seen;
        seen = 0;
        div_i = {W'(4), W'(7), W'(4), W'(3)};
        div_valid_i = '1;
        cyc();
        div_valid_i = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            total++;
            if ({clk_o, clk_en_o, done_o, div_ready_o} !== {m_clk, m_en, m_done, m_rdy}) begin
                bad++;
                $display("FAIL sync_load_model t=%0t got=%h expected=%h", $time,
                         {clk_o, clk_en_o, done_o, div_ready_o}, {m_clk, m_en, m_done, m_rdy});
            end
            seen = (div_ready_o == '1);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL sync_ready_timeout got=%b expected=1111", div_ready_o);
        end
        repeat ($urandom_range(8, 3)) cyc();
        sync_i = 1'b1;
        cyc();
        sync_i = 1'b0;
        cyc();
        total++;
        if ({clk_o, clk_en_o} !== 8'hFF) begin
            bad++;
            $display("FAIL sync_align got=%h expected=ff", {clk_o, clk_en_o});
        end
        cyc();
        total++;
        if (clk_en_o !== 4'h0) begin
            bad++;
            $display("FAIL sync_strobe_once got=%b expected=0000", clk_en_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) begin
                div_valid_i[c]  = ($urandom_range(3) == 0);
                div_i[c*W +: W] = W'($urandom_range(9));
            end
            sync_i = ($urandom_range(19) == 0);
            cyc();
            total++;
            if ({clk_o, clk_en_o, done_o, div_ready_o} !== {m_clk, m_en, m_done, m_rdy}) begin
                bad++;
                $display("FAIL random_model t=%0t got=%h expected=%h", $time,
                         {clk_o, clk_en_o, done_o, div_ready_o}, {m_clk, m_en, m_done, m_rdy});
            end
        end
        div_valid_i = '0;
        sync_i = 1'b0;
    endtask

    task automatic test_reset_pending();
        logic [3:0] pat;
        bit ok;
        pat = 4'b1100;
        ok  = 0;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (div_ready_o[0]) ok = 1;
            else cyc();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstp_ready_timeout got=0 expected=1");
        end
        write(0, 7);
        total++;
        if (div_ready_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL rstp_pending got=%b expected=0", div_ready_o[0]);
        end
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if ({clk_o, clk_en_o, done_o, div_ready_o} !== {4'h0, 4'h0, 4'h0, 4'hF}) begin
            bad++;
            $display("FAIL rstp_immediate got=%h expected=%h", {clk_o, clk_en_o, done_o, div_ready_o}, {4'h0, 4'h0, 4'h0, 4'hF});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            total++;
            if ({clk_o, done_o} !== {{CH{pat[3 - (i % 4)]}}, 4'h0}) begin
                bad++;
                $display("FAIL rstp_resume i=%0d got=%h expected=%h", i, {clk_o, done_o},
                         {{CH{pat[3 - (i % 4)]}}, 4'h0});
            end
            total++;
            if ({clk_o, clk_en_o, done_o, div_ready_o} !== {m_clk, m_en, m_done, m_rdy}) begin
                bad++;
                $display("FAIL rstp_model t=%0t got=%h expected=%h", $time,
                         {clk_o, clk_en_o, done_o, div_ready_o}, {m_clk, m_en, m_done, m_rdy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_load();
        test_stop_restart();
        test_div1_stall();
        test_sync();
        test_random();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
